mips_program_loader: RTL and testbench
======================================

# mips_program_loader

Byte-stream program loader that writes a MIPS program into instruction memory and holds the processor in reset until the image is complete and verified. It sits between a host byte source (serial bridge or testbench) and the write port of instruction memory; its `cpuReset` output drives the processor's `reset` input. The processor is the reader of instruction memory; this block is its writer.

## Interface
- `BASE_ADDRESS`, default 0: byte address of the first loaded word.
- `MAX_WORDS`, default 256: largest accepted word count.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces the idle state immediately.
- `byteData` input 8: stream byte.
- `byteValid` input 1: `byteData` is valid this cycle.
- `byteReady` output 1: loader accepts a byte this cycle.
- `start` input 1: one-cycle pulse that restarts loading from DONE or ERROR.
- `imemWriteEnable` output 1: one-cycle instruction-memory write strobe.
- `imemWriteAddress` output 32: byte address of the word being written.
- `imemWriteData` output 32: instruction word being written.
- `cpuReset` output 1: drives the processor reset; high while loading.
- `loadDone` output 1: image loaded and checksum matched.
- `loadError` output 1: checksum mismatch or oversize count.

## Operation
- **Stream format:**
  - Word count N, 16 bits, high byte first.
  - N instruction words, 4 bytes each, most significant byte first.
  - One checksum byte equal to the XOR of all 4N payload bytes. The count bytes are excluded.
- **Handshake:** a byte is accepted on a rising edge where `byteValid && byteReady`. `byteValid` may drop between bytes for any number of cycles.
- **States:**
  - COUNT_HI: accepted byte is stored as count[15:8], then go to COUNT_LO.
  - COUNT_LO: accepted byte is stored as count[7:0].
    - If count > MAX_WORDS, go to ERROR.
    - If count == 0, go to CHECKSUM.
    - Otherwise go to PAYLOAD.
  - PAYLOAD:
    - Bytes are shifted into a 32-bit assembly register and XORed into an 8-bit running checksum.
    - On the 4th byte of a word, the word is written to memory and the word counter increments.
    - After word N is written, go to CHECKSUM.
  - CHECKSUM: the accepted byte is compared with the running XOR.
    - Equal: go to DONE.
    - Not equal: go to ERROR.
  - DONE and ERROR: no bytes accepted. A `start` pulse returns to COUNT_HI and clears the checksum, word counter, `loadDone` and `loadError`. `cpuReset` returns to 1.
- **Write addressing:** word k (from 0) is written to BASE_ADDRESS + 4k. Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- `start` is ignored in all other states.

## Timing
- **Reset values:** `byteReady`=0, `imemWriteEnable`=0, `imemWriteAddress`=BASE_ADDRESS, `imemWriteData`=0, `cpuReset`=1, `loadDone`=0, `loadError`=0. State is COUNT_HI.
- **Outputs:** all outputs are registered.
- **`byteReady`:**
  - Rises on the first clock edge after `reset` deasserts.
  - High in COUNT_HI, COUNT_LO, PAYLOAD and CHECKSUM.
  - Falls on the edge that enters DONE or ERROR.
  - Never stalls during PAYLOAD, so back-to-back bytes are accepted one per cycle.
- **Write latency:** on the edge accepting a word's 4th byte, `imemWriteEnable`, `imemWriteAddress` and `imemWriteData` are updated together. The strobe is high for exactly the following cycle; the memory captures the word on the next edge. Back-to-back words produce one strobe every 4 cycles.
- **Checksum byte:**
  - Match: on its acceptance edge, `loadDone`=1 and `cpuReset`=0.
  - Mismatch: `loadError`=1 and `cpuReset` stays 1.
- **Oversize count:** `loadError`=1 on the COUNT_LO acceptance edge.
- **`start` in DONE or ERROR:** on the next edge, `cpuReset`=1, flags clear, and `byteReady`=1.
- **Reset mid-operation:** returns to reset values immediately. Partially assembled words are discarded and no strobe is emitted. Words already written stay in memory.

## Test plan
- **Two-word load:** stream 00 02 20 10 00 0A 22 11 00 0A 03, back-to-back.
  - Strobe 1: address BASE, data 0x2010000A.
  - Strobe 2: address BASE+4, data 0x2211000A.
  - Then `loadDone`=1 and `cpuReset`=0.
- **Empty image:** stream 00 00 00 -> no write strobes; `loadDone`=1 on the third byte.
- **Bad checksum:** the two-word stream with the checksum byte set to 0x04 -> both words are written, then `loadError`=1, `cpuReset` stays 1, `byteReady`=0.
- **Oversize count:** MAX_WORDS=256, stream 01 01 -> `loadError`=1 after the second byte and no strobes.
- **Throttled stream:** the two-word stream with `byteValid` low for 3 cycles between every byte -> identical writes and result. Each strobe lasts exactly one cycle.
- **Reset then restart:**
  - Assert `reset` after byte 6 of the two-word stream -> no strobe for the partial word and all outputs at reset values.
  - Then replay the full stream -> correct load.
  - Then pulse `start` and load 00 01 FF FF FF FF 00 -> write 0xFFFFFFFF at BASE and `loadDone`=1.

Source files
------------

// File: rtl/mips_program_loader_if.sv
// -----------------------------------------------------------------------------
// mips_program_loader_if
//
// Bundles the two buses the program loader sits between:
//   * host byte stream   : byteData, byteValid (host -> loader), byteReady
//                          (loader -> host)
//   * imem write port    : imemWriteEnable, imemWriteAddress, imemWriteData
//                          (loader -> instruction memory)
//
// Modports:
//   master : the environment side (host byte source + instruction memory)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface mips_program_loader_if;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [31:0] imemWriteAddress;
  logic [31:0] imemWriteData;

  modport master (
    output byteData,
    output byteValid,
    input  byteReady,
    input  imemWriteEnable,
    input  imemWriteAddress,
    input  imemWriteData
  );

  modport slave (
    input  byteData,
    input  byteValid,
    output byteReady,
    output imemWriteEnable,
    output imemWriteAddress,
    output imemWriteData
  );
endinterface

// File: rtl/mips_program_loader.sv
// -----------------------------------------------------------------------------
// mips_program_loader
//
// Receives a MIPS program image as a byte stream, writes it word by word into
// instruction memory and keeps the processor in reset until the whole image
// has arrived and its XOR checksum matched.
//
// Stream: count[15:8], count[7:0], N x 4 payload bytes (MSB first), then one
// checksum byte = XOR of all payload bytes.
//
// Ports:
//   clk     : single clock, rising edge
//   reset   : asynchronous, active-high; returns everything to the idle values
//   bus     : slave side of mips_program_loader_if (byte stream in,
//             instruction memory write port out)
//   start   : one-cycle pulse, restarts loading from DONE or ERROR
//   cpuReset: processor reset, high while loading or after a failed load
//   loadDone: image complete and checksum matched
//   loadError: checksum mismatch or word count above MAX_WORDS
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mips_program_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MAX_WORDS    = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_program_loader_if.slave        bus,
  input  logic                        start,
  output logic                        cpuReset,
  output logic                        loadDone,
  output logic                        loadError
);

  // 17 bits so a 16-bit count can be compared without truncating MAX_WORDS.
  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    COUNT_HI,
    COUNT_LO,
    PAYLOAD,
    CHECKSUM,
    DONE,
    ERROR
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      stateReg,       stateNext;
  logic [15:0] wordTotalReg,   wordTotalNext;
  logic [15:0] wordCountReg,   wordCountNext;
  logic [1:0]  byteIdxReg,     byteIdxNext;
  logic [23:0] assemblyReg,    assemblyNext;   // first three bytes of a word
  logic [7:0]  checksumReg,    checksumNext;
  logic        byteReadyReg,   byteReadyNext;
  logic        writeEnableReg, writeEnableNext;
  logic [31:0] writeAddrReg,   writeAddrNext;
  logic [31:0] writeDataReg,   writeDataNext;
  logic        cpuResetReg,    cpuResetNext;
  logic        loadDoneReg,    loadDoneNext;
  logic        loadErrorReg,   loadErrorNext;

  logic        accept;
  logic [15:0] countValue;
  logic [31:0] wordAddress;

  assign accept      = bus.byteValid && byteReadyReg;
  // Full count as it stands once the low byte is accepted in COUNT_LO.
  assign countValue  = {wordTotalReg[15:8], bus.byteData};
  // Word k lands at BASE + 4k; the 32-bit add wraps silently by design.
  assign wordAddress = BASE_ADDRESS + {14'd0, wordCountReg, 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg       <= COUNT_HI;
      wordTotalReg   <= '0;
      wordCountReg   <= '0;
      byteIdxReg     <= '0;
      assemblyReg    <= '0;
      checksumReg    <= '0;
      byteReadyReg   <= 1'b0;
      writeEnableReg <= 1'b0;
      writeAddrReg   <= BASE_ADDRESS;
      writeDataReg   <= '0;
      cpuResetReg    <= 1'b1;
      loadDoneReg    <= 1'b0;
      loadErrorReg   <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      wordTotalReg   <= wordTotalNext;
      wordCountReg   <= wordCountNext;
      byteIdxReg     <= byteIdxNext;
      assemblyReg    <= assemblyNext;
      checksumReg    <= checksumNext;
      byteReadyReg   <= byteReadyNext;
      writeEnableReg <= writeEnableNext;
      writeAddrReg   <= writeAddrNext;
      writeDataReg   <= writeDataNext;
      cpuResetReg    <= cpuResetNext;
      loadDoneReg    <= loadDoneNext;
      loadErrorReg   <= loadErrorNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext       = stateReg;
    wordTotalNext   = wordTotalReg;
    wordCountNext   = wordCountReg;
    byteIdxNext     = byteIdxReg;
    assemblyNext    = assemblyReg;
    checksumNext    = checksumReg;
    writeEnableNext = 1'b0;          // strobe is a single-cycle pulse
    writeAddrNext   = writeAddrReg;
    writeDataNext   = writeDataReg;
    cpuResetNext    = cpuResetReg;
    loadDoneNext    = loadDoneReg;
    loadErrorNext   = loadErrorReg;

    case (stateReg)
      COUNT_HI: begin
        if (accept) begin
          wordTotalNext = {bus.byteData, 8'h00};
          stateNext     = COUNT_LO;
        end
      end

      COUNT_LO: begin
        if (accept) begin
          wordTotalNext = countValue;
          if ({1'b0, countValue} > MAX_WORDS_L) begin
            stateNext     = ERROR;
            loadErrorNext = 1'b1;
          end else if (countValue == 16'd0) begin
            stateNext = CHECKSUM;
          end else begin
            stateNext = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          checksumNext = checksumReg ^ bus.byteData;
          byteIdxNext  = byteIdxReg + 2'd1;
          assemblyNext = {assemblyReg[15:0], bus.byteData};
          if (byteIdxReg == 2'd3) begin
            // Word complete: issue the write with the byte that finished it.
            writeEnableNext = 1'b1;
            writeAddrNext   = wordAddress;
            writeDataNext   = {assemblyReg, bus.byteData};
            wordCountNext   = wordCountReg + 16'd1;
            if (wordCountReg + 16'd1 == wordTotalReg) begin
              stateNext = CHECKSUM;
            end
          end
        end
      end

      CHECKSUM: begin
        if (accept) begin
          if (bus.byteData == checksumReg) begin
            stateNext    = DONE;
            loadDoneNext = 1'b1;
            cpuResetNext = 1'b0;     // release the processor
          end else begin
            stateNext     = ERROR;
            loadErrorNext = 1'b1;
          end
        end
      end

      DONE, ERROR: begin
        if (start) begin
          stateNext     = COUNT_HI;
          checksumNext  = '0;
          wordCountNext = '0;
          byteIdxNext   = '0;
          loadDoneNext  = 1'b0;
          loadErrorNext = 1'b0;
          cpuResetNext  = 1'b1;
        end
      end

      default: begin
        stateNext = COUNT_HI;
      end
    endcase

    // Ready is registered from the state being entered, so it falls on the
    // edge that reaches DONE/ERROR and rises on the first edge out of reset.
    byteReadyNext = (stateNext == COUNT_HI) || (stateNext == COUNT_LO) ||
                    (stateNext == PAYLOAD)  || (stateNext == CHECKSUM);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.byteReady        = byteReadyReg;
  assign bus.imemWriteEnable  = writeEnableReg;
  assign bus.imemWriteAddress = writeAddrReg;
  assign bus.imemWriteData    = writeDataReg;
  assign cpuReset             = cpuResetReg;
  assign loadDone             = loadDoneReg;
  assign loadError            = loadErrorReg;

endmodule

// File: tb/tb_mips_program_loader.sv
// -----------------------------------------------------------------------------
// tb_mips_program_loader
//
// Directed bench for mips_program_loader. Bytes are driven on the falling
// edge, outputs are sampled on the falling edge, and a monitor logs every
// instruction-memory write strobe for later comparison.
// -----------------------------------------------------------------------------
module tb_mips_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpuReset;
  logic loadDone;
  logic loadError;

  int checks = 0;
  int errors = 0;

  mips_program_loader_if ifc ();

  mips_program_loader #(
    .BASE_ADDRESS(BASE),
    .MAX_WORDS   (256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc.slave),
    .start    (start),
    .cpuReset (cpuReset),
    .loadDone (loadDone),
    .loadError(loadError)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Strobe monitor
  // ---------------------------------------------------------------------------
  logic [31:0] strobeAddr[$];
  logic [31:0] strobeData[$];
  int          longStrobes = 0;
  logic        prevStrobe  = 1'b0;

  always @(negedge clk) begin
    if (ifc.imemWriteEnable === 1'b1) begin
      strobeAddr.push_back(ifc.imemWriteAddress);
      strobeData.push_back(ifc.imemWriteData);
      if (prevStrobe) longStrobes++;
    end
    prevStrobe = (ifc.imemWriteEnable === 1'b1);
  end

  byte_q_t twoWord = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h0A,
                       8'h22, 8'h11, 8'h00, 8'h0A, 8'h03};

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic clearLog();
    strobeAddr.delete();
    strobeData.delete();
    longStrobes = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int t = 0;
    ifc.byteData  = b;
    ifc.byteValid = 1'b1;
    while (ifc.byteReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout got byteReady=%b want 1", ifc.byteReady);
    end
    @(negedge clk);
    ifc.byteValid = 1'b0;
  endtask

  task automatic sendStream(input byte_q_t s, input int gap);
    foreach (s[i]) begin
      sendByte(s[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ifc.byteReady !== 1'b0) begin errors++; $display("FAIL reset_byteReady got %b want 0", ifc.byteReady); end
    checks++; if (ifc.imemWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_writeEnable got %b want 0", ifc.imemWriteEnable); end
    checks++; if (ifc.imemWriteAddress !== BASE) begin errors++; $display("FAIL reset_writeAddress got %h want %h", ifc.imemWriteAddress, BASE); end
    checks++; if (ifc.imemWriteData !== 32'h0) begin errors++; $display("FAIL reset_writeData got %h want 0", ifc.imemWriteData); end
    checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL reset_cpuReset got %b want 1", cpuReset); end
    checks++; if (loadDone !== 1'b0) begin errors++; $display("FAIL reset_loadDone got %b want 0", loadDone); end
    checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL reset_loadError got %b want 0", loadError); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifc.byteReady !== 1'b1) begin errors++; $display("FAIL reset_release_byteReady got %b want 1", ifc.byteReady); end
    $display("test_reset done");
  endtask

  task automatic test_two_word(input int gap, input string name);
    clearLog();
    sendStream(twoWord, gap);
    checks++; if (strobeAddr.size() != 2) begin errors++; $display("FAIL %s strobe_count got %0d want 2", name, strobeAddr.size()); end
    if (strobeAddr.size() == 2) begin
      checks++; if (strobeAddr[0] !== BASE) begin errors++; $display("FAIL %s addr0 got %h want %h", name, strobeAddr[0], BASE); end
      checks++; if (strobeData[0] !== 32'h2010000A) begin errors++; $display("FAIL %s data0 got %h want 2010000a", name, strobeData[0]); end
      checks++; if (strobeAddr[1] !== BASE + 32'd4) begin errors++; $display("FAIL %s addr1 got %h want %h", name, strobeAddr[1], BASE + 32'd4); end
      checks++; if (strobeData[1] !== 32'h2211000A) begin errors++; $display("FAIL %s data1 got %h want 2211000a", name, strobeData[1]); end
    end
    checks++; if (longStrobes != 0) begin errors++; $display("FAIL %s strobe_width got %0d multi-cycle want 0", name, longStrobes); end
    checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL %s loadDone got %b want 1", name, loadDone); end
    checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL %s loadError got %b want 0", name, loadError); end
    checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL %s cpuReset got %b want 0", name, cpuReset); end
    checks++; if (ifc.byteReady !== 1'b0) begin errors++; $display("FAIL %s byteReady got %b want 0", name, ifc.byteReady); end
    $display("%s done strobes=%0d loadDone=%b cpuReset=%b", name, strobeAddr.size(), loadDone, cpuReset);
  endtask

  task automatic test_start();
    pulseStart();
    checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL start_cpuReset got %b want 1", cpuReset); end
    checks++; if (loadDone !== 1'b0 || loadError !== 1'b0) begin errors++; $display("FAIL start_flags got done=%b err=%b want 0 0", loadDone, loadError); end
    checks++; if (ifc.byteReady !== 1'b1) begin errors++; $display("FAIL start_byteReady got %b want 1", ifc.byteReady); end
    $display("test_start done cpuReset=%b", cpuReset);
  endtask

  task automatic test_empty();
    byte_q_t s = '{8'h00, 8'h00, 8'h00};
    clearLog();
    sendStream(s, 0);
    checks++; if (strobeAddr.size() != 0) begin errors++; $display("FAIL empty strobe_count got %0d want 0", strobeAddr.size()); end
    checks++; if (loadDone !== 1'b1) begin errors++; $display("FAIL empty loadDone got %b want 1", loadDone); end
    checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL empty cpuReset got %b want 0", cpuReset); end
    $display("test_empty done loadDone=%b", loadDone);
  endtask

  task automatic test_bad_checksum();
    byte_q_t s = twoWord;
    s[10] = 8'h04;
    clearLog();
    sendStream(s, 0);
    checks++; if (strobeAddr.size() != 2) begin errors++; $display("FAIL bad_checksum strobe_count got %0d want 2", strobeAddr.size()); end
    checks++; if (loadError !== 1'b1) begin errors++; $display("FAIL bad_checksum loadError got %b want 1", loadError); end
    checks++; if (loadDone !== 1'b0) begin errors++; $display("FAIL bad_checksum loadDone got %b want 0", loadDone); end
    checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL bad_checksum cpuReset got %b want 1", cpuReset); end
    checks++; if (ifc.byteReady !== 1'b0) begin errors++; $display("FAIL bad_checksum byteReady got %b want 0", ifc.byteReady); end
    $display("test_bad_checksum done loadError=%b", loadError);
  endtask

  task automatic test_oversize();
    byte_q_t s = '{8'h01, 8'h01};
    clearLog();
    sendStream(s, 0);
    checks++; if (loadError !== 1'b1) begin errors++; $display("FAIL oversize loadError got %b want 1", loadError); end
    checks++; if (ifc.byteReady !== 1'b0) begin errors++; $display("FAIL oversize byteReady got %b want 0", ifc.byteReady); end
    checks++; if (strobeAddr.size() != 0) begin errors++; $display("FAIL oversize strobe_count got %0d want 0", strobeAddr.size()); end
    $display("test_oversize done loadError=%b", loadError);
  endtask

  // Count equal to MAX_WORDS must be accepted; abandon the load via reset.
  task automatic test_max_count();
    byte_q_t s = '{8'h01, 8'h00};
    clearLog();
    sendStream(s, 0);
    checks++; if (loadError !== 1'b0) begin errors++; $display("FAIL max_count loadError got %b want 0", loadError); end
    checks++; if (ifc.byteReady !== 1'b1) begin errors++; $display("FAIL max_count byteReady got %b want 1", ifc.byteReady); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("test_max_count done loadError=%b", loadError);
  endtask

  task automatic test_reset_restart();
    byte_q_t partial = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h0A};
    byte_q_t single  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    clearLog();
    sendStream(partial, 0);
    #2 reset = 1'b1;
    #1;
    checks++; if (ifc.imemWriteEnable !== 1'b0) begin errors++; $display("FAIL midreset_writeEnable got %b want 0", ifc.imemWriteEnable); end
    checks++; if (ifc.imemWriteAddress !== BASE || ifc.imemWriteData !== 32'h0) begin errors++; $display("FAIL midreset_bus got addr=%h data=%h want %h 0", ifc.imemWriteAddress, ifc.imemWriteData, BASE); end
    checks++; if (ifc.byteReady !== 1'b0 || cpuReset !== 1'b1) begin errors++; $display("FAIL midreset_ctrl got ready=%b cpuReset=%b want 0 1", ifc.byteReady, cpuReset); end
    checks++; if (loadDone !== 1'b0 || loadError !== 1'b0) begin errors++; $display("FAIL midreset_flags got done=%b err=%b want 0 0", loadDone, loadError); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Only the completed first word may have been written.
    checks++; if (strobeAddr.size() != 1) begin errors++; $display("FAIL midreset_strobe_count got %0d want 1", strobeAddr.size()); end
    $display("reset_mid_stream done strobes=%0d", strobeAddr.size());

    test_two_word(0, "replay_after_reset");

    pulseStart();
    clearLog();
    sendStream(single, 0);
    checks++; if (strobeAddr.size() != 1) begin errors++; $display("FAIL single strobe_count got %0d want 1", strobeAddr.size()); end
    if (strobeAddr.size() == 1) begin
      checks++; if (strobeAddr[0] !== BASE) begin errors++; $display("FAIL single addr got %h want %h", strobeAddr[0], BASE); end
      checks++; if (strobeData[0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL single data got %h want ffffffff", strobeData[0]); end
    end
    checks++; if (loadDone !== 1'b1 || cpuReset !== 1'b0) begin errors++; $display("FAIL single result got done=%b cpuReset=%b want 1 0", loadDone, cpuReset); end
    $display("restart_single_word done loadDone=%b", loadDone);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    ifc.byteValid = 1'b0;
    ifc.byteData  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_two_word(0, "two_word");
    test_start();
    test_empty();
    pulseStart();
    test_bad_checksum();
    pulseStart();
    test_oversize();
    pulseStart();
    test_max_count();
    test_two_word(3, "throttled");
    pulseStart();
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
